control_venta: RTL and testbench



---
 rtl/venta_pkg.sv | 20 ++
 rtl/display_7seg_hex.sv | 13 +
 rtl/control_venta.sv | 202 ++++++++++++++++++++
 tb/tb_control_venta.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/venta_pkg.sv
// venta_pkg: shared types and constants for the vending controller.
//   venta_state_e : controller state, encoding matches the estado_actual output.
//   SEG_HEX       : active-high 7-segment patterns for hex digits 0..F,
//                   bit 0 = segment a ... bit 6 = segment g.
package venta_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCredit   = 2'd1,
        StDispense = 2'd2,
        StRefund   = 2'd3
    } venta_state_e;

    // Index 0 sits in the least significant slot.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/display_7seg_hex.sv
// display_7seg_hex: combinational hex digit to 7-segment decoder.
//   i_hex [3:0] : digit to display
//   o_seg [6:0] : active-high segments, o_seg[0] = a ... o_seg[6] = g
module display_7seg_hex
    import venta_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_hex];

endmodule

// File: rtl/control_venta.sv
// control_venta: sequential vending controller.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   coin_in/coin_value  : async coin strobe and its value
//   sel                 : product select, price = PRICE_BASE + sel * PRICE_STEP
//   buy, cancel         : async purchase / refund requests
//   credit, hay_credito : saturating credit and its nonzero flag
//   estado_actual       : IDLE=0, CREDIT=1, DISPENSE=2, REFUND=3
//   dispense            : high for DISP_CYCLES cycles per sale
//   no_funds, refund_valid, coin_reject : one-cycle pulses
//   refund_amount       : last refunded credit, held
//   overflow            : sticky coin saturation flag, cleared by refund
//   seg                 : active-high 7-segment hex view of credit[3:0]
// Build option: define CONTROL_VENTA_DEBOUNCE_EN to add a DEB_CYCLES
// stability filter on each async input after synchronisation.
module control_venta
    import venta_pkg::*;
#(
    parameter int unsigned CRED_W      = 6,
    parameter int unsigned VAL_W       = 3,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned PRICE_BASE  = 3,
    parameter int unsigned PRICE_STEP  = 2,
    parameter int unsigned DISP_CYCLES = 4,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              coin_in,
    input  logic [VAL_W-1:0]  coin_value,
    input  logic [SEL_W-1:0]  sel,
    input  logic              buy,
    input  logic              cancel,
    output logic [CRED_W-1:0] credit,
    output logic              hay_credito,
    output logic [1:0]        estado_actual,
    output logic              dispense,
    output logic              no_funds,
    output logic              refund_valid,
    output logic [CRED_W-1:0] refund_amount,
    output logic              coin_reject,
    output logic              overflow,
    output logic [6:0]        seg
);

    localparam int unsigned SUM_W  = CRED_W + 1;
    localparam int unsigned DISP_W = $clog2(DISP_CYCLES + 1);
    localparam logic [SUM_W-1:0] CRED_MAX = SUM_W'((1 << CRED_W) - 1);

    // Input conditioning: bit 0 = coin, 1 = buy, 2 = cancel.
    logic [2:0] w_raw;
    logic [2:0] w_ev;
    assign w_raw = {cancel, buy, coin_in};

    for (genvar gi = 0; gi < 3; gi++) begin : g_in
        logic r_s1, r_s2, r_prev;
`ifdef CONTROL_VENTA_DEBOUNCE_EN
        localparam int unsigned DEB_CNT_W = $clog2(DEB_CYCLES + 1);
        logic [DEB_CNT_W-1:0] r_cnt;
        logic                 r_lvl;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_lvl  <= 1'b0;
                r_cnt  <= '0;
                r_prev <= 1'b0;
            end else begin
                r_s1   <= w_raw[gi];
                r_s2   <= r_s1;
                r_prev <= r_lvl;
                // Adopt the new level only after DEB_CYCLES consecutive disagreeing samples.
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEB_CNT_W'(DEB_CYCLES - 1)) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
        assign w_ev[gi] = r_lvl & ~r_prev;
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_prev <= 1'b0;
            end else begin
                r_s1   <= w_raw[gi];
                r_s2   <= r_s1;
                r_prev <= r_s2;
            end
        end
        assign w_ev[gi] = r_s2 & ~r_prev;
`endif
    end

    venta_state_e      r_state;
    logic [CRED_W-1:0] r_credit;
    logic [DISP_W-1:0] r_disp_cnt;
    logic              r_dispense, r_no_funds, r_refund_valid, r_coin_reject, r_overflow;
    logic [CRED_W-1:0] r_refund_amount;

    logic              w_coin_ev, w_buy_ev, w_cancel_ev;
    logic              w_coin_ok, w_buy_ok, w_sat;
    logic [SUM_W-1:0]  w_price, w_base, w_sum;
    logic [CRED_W-1:0] w_credit_nx;

    assign w_coin_ev   = w_ev[0];
    assign w_buy_ev    = w_ev[1];
    assign w_cancel_ev = w_ev[2];

    // Price check uses pre-coin credit; a same-cycle coin is added after the debit.
    always_comb begin
        w_price   = SUM_W'(PRICE_BASE) + SUM_W'(sel) * SUM_W'(PRICE_STEP);
        w_coin_ok = w_coin_ev && (r_state != StRefund);
        w_buy_ok  = w_buy_ev && !w_cancel_ev && (r_state == StCredit)
                    && ({1'b0, r_credit} >= w_price);
        w_base    = w_buy_ok ? ({1'b0, r_credit} - w_price) : {1'b0, r_credit};
        w_sum     = w_base + (w_coin_ok ? SUM_W'(coin_value) : '0);
        w_sat     = w_sum > CRED_MAX;
        w_credit_nx = w_sat ? CRED_MAX[CRED_W-1:0] : w_sum[CRED_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StIdle;
            r_credit        <= '0;
            r_disp_cnt      <= '0;
            r_dispense      <= 1'b0;
            r_no_funds      <= 1'b0;
            r_refund_valid  <= 1'b0;
            r_refund_amount <= '0;
            r_coin_reject   <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_no_funds     <= 1'b0;
            r_refund_valid <= 1'b0;
            r_coin_reject  <= w_coin_ev && (r_state == StRefund);
            if (w_coin_ok && w_sat) begin
                r_overflow <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    r_credit <= w_credit_nx;
                    if (w_buy_ev) begin
                        r_no_funds <= 1'b1;
                    end
                    if (w_credit_nx != '0) begin
                        r_state <= StCredit;
                    end
                end
                StCredit: begin
                    r_credit <= w_credit_nx;
                    if (w_cancel_ev) begin
                        r_state         <= StRefund;
                        r_refund_valid  <= 1'b1;
                        r_refund_amount <= w_credit_nx;
                    end else if (w_buy_ok) begin
                        r_state    <= StDispense;
                        r_dispense <= 1'b1;
                        r_disp_cnt <= DISP_W'(DISP_CYCLES - 1);
                    end else if (w_buy_ev) begin
                        r_no_funds <= 1'b1;
                    end
                end
                StDispense: begin
                    r_credit <= w_credit_nx;
                    if (r_disp_cnt == '0) begin
                        r_dispense <= 1'b0;
                        r_state    <= (w_credit_nx != '0) ? StCredit : StIdle;
                    end else begin
                        r_disp_cnt <= r_disp_cnt - 1'b1;
                    end
                end
                StRefund: begin
                    r_credit   <= '0;
                    r_overflow <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign credit        = r_credit;
    assign hay_credito   = (r_credit != '0);
    assign estado_actual = r_state;
    assign dispense      = r_dispense;
    assign no_funds      = r_no_funds;
    assign refund_valid  = r_refund_valid;
    assign refund_amount = r_refund_amount;
    assign coin_reject   = r_coin_reject;
    assign overflow      = r_overflow;

    display_7seg_hex u_display (
        .i_hex (r_credit[3:0]),
        .o_seg (seg)
    );

endmodule

// File: tb/tb_control_venta.sv
// tb_control_venta: directed self-checking bench for control_venta.
module tb_control_venta;

`ifdef CONTROL_VENTA_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_in, buy, cancel;
    logic [2:0] coin_value;
    logic [1:0] sel;
    logic [5:0] credit, refund_amount;
    logic       hay_credito, dispense, no_funds, refund_valid, coin_reject, overflow;
    logic [1:0] estado_actual;
    logic [6:0] seg;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    control_venta dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_in       (coin_in),
        .coin_value    (coin_value),
        .sel           (sel),
        .buy           (buy),
        .cancel        (cancel),
        .credit        (credit),
        .hay_credito   (hay_credito),
        .estado_actual (estado_actual),
        .dispense      (dispense),
        .no_funds      (no_funds),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .coin_reject   (coin_reject),
        .overflow      (overflow),
        .seg           (seg)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_coin(input logic [2:0] v);
        coin_value = v;
        coin_in    = 1'b1;
        step(LAT);
        coin_in    = 1'b0;
        step(LAT + 1);
    endtask

    initial begin
        rst_n = 1'b0; coin_in = 1'b0; buy = 1'b0; cancel = 1'b0;
        coin_value = 3'd0; sel = 2'd0;
        step(2);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_hay", 32'(hay_credito), 32'd0);
        chk("rst_state", 32'(estado_actual), 32'd0);
        chk("rst_pulses", 32'({dispense, no_funds, refund_valid, coin_reject, overflow}), 32'd0);
        chk("rst_refamt", 32'(refund_amount), 32'd0);
        chk("rst_seg", 32'(seg), 32'h3F);
        rst_n = 1'b1;
        step(2);

        // First coin: not visible one edge early, visible at full latency.
        coin_value = 3'd3;
        coin_in    = 1'b1;
        step(LAT - 1);
        chk("coin_early", 32'(credit), 32'd0);
        step(1);
        chk("coin3_credit", 32'(credit), 32'd3);
        chk("coin3_hay", 32'(hay_credito), 32'd1);
        chk("coin3_state", 32'(estado_actual), 32'd1);
        chk("coin3_seg", 32'(seg), 32'h4F);
        coin_in = 1'b0;
        step(LAT + 1);

        // Buy with insufficient credit (price 5).
        sel = 2'd1;
        buy = 1'b1;
        step(LAT);
        chk("nf_pulse", 32'(no_funds), 32'd1);
        chk("nf_credit", 32'(credit), 32'd3);
        chk("nf_state", 32'(estado_actual), 32'd1);
        step(1);
        chk("nf_oneshot", 32'(no_funds), 32'd0);
        buy = 1'b0;
        step(LAT + 1);

        // 3 + 4 = 7, buy price 5 -> dispense with 2 left.
        do_coin(3'd4);
        chk("coin4_credit", 32'(credit), 32'd7);
        buy = 1'b1;
        step(LAT);
        chk("disp_state", 32'(estado_actual), 32'd2);
        chk("disp_credit", 32'(credit), 32'd2);
        chk("disp_rise", 32'(dispense), 32'd1);
        step(3);
        chk("disp_hold", 32'(dispense), 32'd1);
        step(1);
        chk("disp_fall", 32'(dispense), 32'd0);
        chk("disp_exit", 32'(estado_actual), 32'd1);
        chk("disp_seg", 32'(seg), 32'h5B);
        buy = 1'b0;
        step(LAT + 1);

        // Cancel and buy together: cancel wins.
        sel    = 2'd0;
        cancel = 1'b1;
        buy    = 1'b1;
        step(LAT);
        chk("ref_state", 32'(estado_actual), 32'd3);
        chk("ref_valid", 32'(refund_valid), 32'd1);
        chk("ref_amount", 32'(refund_amount), 32'd2);
        chk("ref_nodisp", 32'({dispense, no_funds}), 32'd0);
        step(1);
        chk("ref_idle", 32'(estado_actual), 32'd0);
        chk("ref_credit0", 32'(credit), 32'd0);
        chk("ref_vpulse", 32'(refund_valid), 32'd0);
        chk("ref_hold", 32'(refund_amount), 32'd2);
        cancel = 1'b0;
        buy    = 1'b0;
        step(LAT + 1);

        // Fill to 62, then a 7 saturates at 63.
        for (int i = 0; i < 8; i++) do_coin(3'd7);
        do_coin(3'd6);
        chk("fill62", 32'(credit), 32'd62);
        chk("fill62_ovf", 32'(overflow), 32'd0);
        do_coin(3'd7);
        chk("sat_credit", 32'(credit), 32'd63);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_seg", 32'(seg), 32'h71);

        // Cancel, then a coin landing while in REFUND.
        cancel = 1'b1;
        step(1);
        coin_value = 3'd5;
        coin_in    = 1'b1;
        step(LAT - 1);
        chk("ref2_state", 32'(estado_actual), 32'd3);
        chk("ref2_amount", 32'(refund_amount), 32'd63);
        step(1);
        chk("rej_pulse", 32'(coin_reject), 32'd1);
        chk("rej_credit", 32'(credit), 32'd0);
        chk("rej_ovf_clr", 32'(overflow), 32'd0);
        chk("rej_state", 32'(estado_actual), 32'd0);
        step(1);
        chk("rej_oneshot", 32'(coin_reject), 32'd0);
        cancel  = 1'b0;
        coin_in = 1'b0;
        step(LAT + 1);

        // Zero-value coin and buy in IDLE.
        do_coin(3'd0);
        chk("zero_credit", 32'(credit), 32'd0);
        chk("zero_state", 32'(estado_actual), 32'd0);
        buy = 1'b1;
        step(LAT);
        chk("idle_nf", 32'(no_funds), 32'd1);
        buy = 1'b0;
        step(LAT + 1);

`ifdef CONTROL_VENTA_DEBOUNCE_EN
        coin_value = 3'd3;
        coin_in    = 1'b1;
        step(2);
        coin_in = 1'b0;
        step(LAT + 2);
        chk("glitch", 32'(credit), 32'd0);
        coin_in = 1'b1;
        step(6);
        coin_in = 1'b0;
        step(1);
        chk("deb_coin", 32'(credit), 32'd3);
        step(LAT + 2);
        chk("deb_once", 32'(credit), 32'd3);
        do_coin(3'd4);
`else
        do_coin(3'd7);
`endif

        // Reset in the middle of a dispense.
        sel = 2'd0;
        buy = 1'b1;
        step(LAT);
        chk("rd_disp", 32'(dispense), 32'd1);
        chk("rd_credit", 32'(credit), 32'd4);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("rd_abort", 32'(dispense), 32'd0);
        chk("rd_state", 32'(estado_actual), 32'd0);
        chk("rd_credit0", 32'(credit), 32'd0);
        buy = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(LAT + 4);
        chk("rd_quiet", 32'({dispense, no_funds, refund_valid, coin_reject}), 32'd0);
        chk("rd_seg", 32'(seg), 32'h3F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
